// File: rtl/icache_axi_refill_pkg.sv
// Shared types and constants for the ICache AXI refill responder.
// Also the home of the configured cache line width.
package icache_axi_refill_pkg;

    // Cache line width used by the refill path.
    localparam int unsigned ICACHELINE_WIDTH = 128;

    // AXI4 encodings used on the read address and response channels.
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Refill sequencing: idle, address phase, data beats, line response.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAr   = 2'd1,
        StR    = 2'd2,
        StResp = 2'd3
    } refill_state_e;

endpackage

// File: rtl/icache_axi_refill_if.sv
// Bundle of the cache-side refill handshake and the AXI4 read channels.
// The master modport is the refill block; the slave modport is the
// environment (the ICache on one side, the AXI interconnect on the other).
interface icache_axi_refill_if
    import icache_axi_refill_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINE_WIDTH     = ICACHELINE_WIDTH,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    // Cache side
    logic                      rreq_i;
    logic [ADDR_WIDTH-1:0]     addr_i;
    logic                      rdy_o;
    logic                      rvalid_o;
    logic [1:0]                rlast_o;
    logic [LINE_WIDTH-1:0]     rdata_o;

    // AXI read address channel
    logic [3:0]                arid_o;
    logic [ADDR_WIDTH-1:0]     araddr_o;
    logic [7:0]                arlen_o;
    logic [2:0]                arsize_o;
    logic [1:0]                arburst_o;
    logic                      arvalid_o;
    logic                      arready_i;

    // AXI read data channel
    logic [AXI_DATA_WIDTH-1:0] rdata_i;
    logic [1:0]                rresp_i;
    logic                      rlast_i;
    logic                      rvalid_i;
    logic                      rready_o;

    modport master (
        input  rreq_i, addr_i, arready_i, rdata_i, rresp_i, rlast_i, rvalid_i,
        output rdy_o, rvalid_o, rlast_o, rdata_o,
        output arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o, rready_o
    );

    modport slave (
        output rreq_i, addr_i, arready_i, rdata_i, rresp_i, rlast_i, rvalid_i,
        input  rdy_o, rvalid_o, rlast_o, rdata_o,
        input  arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o, rready_o
    );

endinterface

// File: rtl/icache_axi_refill.sv
// ICache refill responder: turns one line request into one AXI4 read burst,
// assembles the beats into a line buffer and returns it as a single pulse.
// Optional feature macro ICACHE_CRITICAL_WORD_FIRST_EN: issue a WRAP burst
// starting at the requested word; beats are steered so the line layout is
// identical to the default INCR, line-aligned burst.
module icache_axi_refill
    import icache_axi_refill_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINE_WIDTH     = ICACHELINE_WIDTH,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter logic [3:0]  AXI_ID         = 4'h0
) (
    input logic               clk,
    input logic               rst,
    icache_axi_refill_if.master bus
);

    localparam int unsigned BEATS    = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int unsigned CNT_W    = $clog2(BEATS);
    localparam int unsigned WORD_LSB = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned LINE_LSB = $clog2(LINE_WIDTH / 8);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [7:0]       ARLEN    = 8'(BEATS - 1);

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    // Keep the word offset so the burst starts at the critical word.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << WORD_LSB) - ADDR_WIDTH'(1));
    localparam logic [1:0] BURST = AXI_BURST_WRAP;
`else
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << LINE_LSB) - ADDR_WIDTH'(1));
    localparam logic [1:0] BURST = AXI_BURST_INCR;
`endif

    refill_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [LINE_WIDTH-1:0]     line_q, line_d;
    logic [LINE_WIDTH-1:0]     rdata_q, rdata_d;

    logic [CNT_W-1:0]          start_lane;
    logic [CNT_W-1:0]          lane;
    logic                      last_by_cnt;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign start_lane = addr_q[WORD_LSB +: CNT_W];
`else
    assign start_lane = '0;
`endif

    // Wrapping add: beat k lands in lane (start + k) mod BEATS.
    assign lane        = start_lane + cnt_q;
    assign last_by_cnt = (cnt_q == LAST_CNT);

    // Next-state, beat assembly and error tracking.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        line_d  = line_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (bus.rreq_i) begin
                    addr_d  = bus.addr_i & ALIGN_MASK;
                    line_d  = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StAr;
                end
            end
            StAr: begin
                if (bus.arready_i) begin
                    state_d = StR;
                end
            end
            StR: begin
                if (bus.rvalid_i) begin
                    for (int k = 0; k < int'(BEATS); k++) begin
                        if (lane == CNT_W'(k)) begin
                            line_d[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = bus.rdata_i;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    // Early rlast or a missing rlast on the final beat both flag an error.
                    err_d = err_q | (bus.rresp_i != AXI_RESP_OKAY) | (bus.rlast_i ^ last_by_cnt);
                    if (bus.rlast_i || last_by_cnt) begin
                        rdata_d = line_d;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
        end
    end

    // Moore outputs; AR payload is zero outside the address phase.
    always_comb begin
        bus.rdy_o     = (state_q == StIdle);
        bus.arvalid_o = (state_q == StAr);
        bus.rready_o  = (state_q == StR);
        bus.rvalid_o  = (state_q == StResp);
        bus.rlast_o   = 2'b00;
        bus.rdata_o   = rdata_q;
        bus.arid_o    = 4'h0;
        bus.araddr_o  = '0;
        bus.arlen_o   = 8'h00;
        bus.arsize_o  = 3'b000;
        bus.arburst_o = 2'b00;
        if (state_q == StAr) begin
            bus.arid_o    = AXI_ID;
            bus.araddr_o  = addr_q;
            bus.arlen_o   = ARLEN;
            bus.arsize_o  = AXI_SIZE_4B;
            bus.arburst_o = BURST;
        end
        if (state_q == StResp) begin
            bus.rlast_o = {err_q, 1'b1};
        end
    end

endmodule
